// File: rtl/memory_access_stage.sv
// MEM stage of the pipelined RV32I core: word loads/stores over a req/ready data port, pipeline stall and MEM/WB register.
// Optional access timeout and sticky fault flag are built only when DMEM_TIMEOUT_EN is defined.
module memory_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_ALU_OUT,
    input  logic [31:0] EX_MEM_writedata,
    input  logic [4:0]  EX_MEM_RD,
    input  logic        EX_MEM_memwrite_en,
    input  logic        EX_MEM_regwrite_en,
    input  logic        EX_MEM_wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEM_EX_ALU_OUT,
    output logic [31:0] MEM_WB_ALU_OUT,
    output logic [31:0] MEM_WB_RDATA,
    output logic [4:0]  MEM_WB_RD,
    output logic        MEM_WB_regwrite_en,
    output logic        MEM_WB_wb_sel,
    output logic        dmem_fault
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state;

    logic [31:0] cap_alu;
    logic [31:0] cap_wdata;
    logic [4:0]  cap_rd;
    logic        cap_we;
    logic        cap_regwrite;
    logic        cap_wb_sel;
    logic        cap_load;

    logic        is_store;
    logic        is_load;
    logic        is_access;
    logic        timeout_hit;
    logic        wait_done;

    assign is_store  = EX_MEM_memwrite_en;
    assign is_load   = EX_MEM_wb_sel & EX_MEM_regwrite_en & ~EX_MEM_memwrite_en;
    assign is_access = is_store | is_load;
    assign cap_load  = cap_wb_sel & cap_regwrite & ~cap_we;
    assign wait_done = dmem_ready | timeout_hit;

    assign MEM_EX_ALU_OUT = EX_MEM_ALU_OUT;

    // Reset gates the request and stall so an abandoned WAIT drops them in the same cycle.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        mem_stall  = 1'b0;
        case (state)
            S_IDLE: begin
                dmem_req   = is_access;
                dmem_we    = is_store;
                dmem_addr  = {EX_MEM_ALU_OUT[31:2], 2'b00};
                dmem_wdata = EX_MEM_writedata;
                mem_stall  = is_access & ~dmem_ready;
            end
            S_WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = cap_we;
                dmem_addr  = {cap_alu[31:2], 2'b00};
                dmem_wdata = cap_wdata;
                mem_stall  = ~wait_done;
            end
            default: begin
                dmem_req  = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
        if (rst) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            cap_alu            <= '0;
            cap_wdata          <= '0;
            cap_rd             <= '0;
            cap_we             <= 1'b0;
            cap_regwrite       <= 1'b0;
            cap_wb_sel         <= 1'b0;
            MEM_WB_ALU_OUT     <= '0;
            MEM_WB_RDATA       <= '0;
            MEM_WB_RD          <= '0;
            MEM_WB_regwrite_en <= 1'b0;
            MEM_WB_wb_sel      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_access && !dmem_ready) begin
                        state              <= S_WAIT;
                        cap_alu            <= EX_MEM_ALU_OUT;
                        cap_wdata          <= EX_MEM_writedata;
                        cap_rd             <= EX_MEM_RD;
                        cap_we             <= is_store;
                        cap_regwrite       <= EX_MEM_regwrite_en;
                        cap_wb_sel         <= EX_MEM_wb_sel;
                        MEM_WB_RD          <= '0;
                        MEM_WB_regwrite_en <= 1'b0;
                        MEM_WB_wb_sel      <= 1'b0;
                    end else begin
                        MEM_WB_ALU_OUT     <= EX_MEM_ALU_OUT;
                        MEM_WB_RD          <= EX_MEM_RD;
                        MEM_WB_regwrite_en <= EX_MEM_regwrite_en;
                        MEM_WB_wb_sel      <= EX_MEM_wb_sel;
                        if (is_load) begin
                            MEM_WB_RDATA <= dmem_rdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_done) begin
                        state              <= S_IDLE;
                        MEM_WB_ALU_OUT     <= cap_alu;
                        MEM_WB_RD          <= cap_rd;
                        MEM_WB_regwrite_en <= cap_regwrite;
                        MEM_WB_wb_sel      <= cap_wb_sel;
                        if (cap_load) begin
                            MEM_WB_RDATA <= dmem_ready ? dmem_rdata : '0;
                        end
                    end else begin
                        MEM_WB_RD          <= '0;
                        MEM_WB_regwrite_en <= 1'b0;
                        MEM_WB_wb_sel      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] wait_cnt;

    // Counter sits at zero in IDLE, so it is already cleared on entry to WAIT.
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            dmem_fault <= 1'b0;
        end else begin
            if (state == S_IDLE || wait_done) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit && !dmem_ready) begin
                dmem_fault <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign dmem_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized self-checking bench for memory_access_stage against a transaction-level reference model.
// Build with DMEM_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES = 4).
module tb_memory_access_stage;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        mw;
        logic        rw;
        logic        ws;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_MEM_ALU_OUT;
    logic [31:0] EX_MEM_writedata;
    logic [4:0]  EX_MEM_RD;
    logic        EX_MEM_memwrite_en;
    logic        EX_MEM_regwrite_en;
    logic        EX_MEM_wb_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] MEM_EX_ALU_OUT;
    logic [31:0] MEM_WB_ALU_OUT;
    logic [31:0] MEM_WB_RDATA;
    logic [4:0]  MEM_WB_RD;
    logic        MEM_WB_regwrite_en;
    logic        MEM_WB_wb_sel;
    logic        dmem_fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_alu, exp_rdata;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_ws, exp_fault;
    logic [31:0] mem [logic [31:0]];

    memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_ALU_OUT(EX_MEM_ALU_OUT), .EX_MEM_writedata(EX_MEM_writedata),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_memwrite_en(EX_MEM_memwrite_en),
        .EX_MEM_regwrite_en(EX_MEM_regwrite_en), .EX_MEM_wb_sel(EX_MEM_wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .MEM_EX_ALU_OUT(MEM_EX_ALU_OUT),
        .MEM_WB_ALU_OUT(MEM_WB_ALU_OUT), .MEM_WB_RDATA(MEM_WB_RDATA),
        .MEM_WB_RD(MEM_WB_RD), .MEM_WB_regwrite_en(MEM_WB_regwrite_en),
        .MEM_WB_wb_sel(MEM_WB_wb_sel), .dmem_fault(dmem_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic drive(input instr_t ins);
        EX_MEM_ALU_OUT     = ins.alu;
        EX_MEM_writedata   = ins.wdata;
        EX_MEM_RD          = ins.rd;
        EX_MEM_memwrite_en = ins.mw;
        EX_MEM_regwrite_en = ins.rw;
        EX_MEM_wb_sel      = ins.ws;
    endtask

    task automatic drive_random_inputs();
        EX_MEM_ALU_OUT     = $urandom;
        EX_MEM_writedata   = $urandom;
        EX_MEM_RD          = 5'($urandom);
        EX_MEM_memwrite_en = 1'($urandom);
        EX_MEM_regwrite_en = 1'($urandom);
        EX_MEM_wb_sel      = 1'($urandom);
    endtask

    // Issue one EX/MEM instruction; memory answers `lat` cycles after the first request cycle.
    task automatic run_instr(input instr_t ins, input int lat, input bit scramble);
        bit          st, ld, acc, timed_out;
        int          done_cyc;
        logic [31:0] waddr, rword;
        st  = ins.mw;
        ld  = ins.ws & ins.rw & ~ins.mw;
        acc = st | ld;
        waddr = ins.alu & 32'hFFFF_FFFC;
        timed_out = 1'b0;
        done_cyc  = acc ? lat : 0;
`ifdef DMEM_TIMEOUT_EN
        if (acc && lat > TO + 1) begin
            done_cyc  = TO + 1;
            timed_out = 1'b1;
        end
`endif
        rword = 32'h0;
        if (ld && !timed_out) rword = mem_read(waddr);
        drive(ins);
        for (int c = 0; c <= done_cyc; c++) begin
            if (c > 0 && scramble) drive_random_inputs();
            dmem_ready = acc ? (c == lat) : 1'($urandom);
            dmem_rdata = (ld && c == lat) ? rword : $urandom;
            @(negedge clk);
            n_checks++;
            if (dmem_req !== acc) begin
                n_fail++; $display("FAIL req cyc=%0d got=%b exp=%b", c, dmem_req, acc);
            end
            n_checks++;
            if (mem_stall !== (acc && c < done_cyc)) begin
                n_fail++; $display("FAIL stall cyc=%0d got=%b exp=%b", c, mem_stall, acc && c < done_cyc);
            end
            n_checks++;
            if (MEM_EX_ALU_OUT !== EX_MEM_ALU_OUT) begin
                n_fail++; $display("FAIL fwd got=%h exp=%h", MEM_EX_ALU_OUT, EX_MEM_ALU_OUT);
            end
            n_checks++;
            if (dmem_fault !== exp_fault) begin
                n_fail++; $display("FAIL fault got=%b exp=%b", dmem_fault, exp_fault);
            end
            if (acc) begin
                n_checks++;
                if (dmem_we !== st || dmem_addr !== waddr || dmem_wdata !== ins.wdata) begin
                    n_fail++;
                    $display("FAIL port cyc=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                             c, dmem_we, dmem_addr, dmem_wdata, st, waddr, ins.wdata);
                end
            end
            @(posedge clk); #1;
            if (c < done_cyc) begin
                n_checks++;
                if (MEM_WB_regwrite_en !== 1'b0 || MEM_WB_RD !== 5'd0 || MEM_WB_wb_sel !== 1'b0 ||
                    MEM_WB_ALU_OUT !== exp_alu || MEM_WB_RDATA !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL bubble cyc=%0d got rw=%b rd=%0d ws=%b alu=%h rdata=%h exp 0/0/0 alu=%h rdata=%h",
                             c, MEM_WB_regwrite_en, MEM_WB_RD, MEM_WB_wb_sel, MEM_WB_ALU_OUT,
                             MEM_WB_RDATA, exp_alu, exp_rdata);
                end
            end
        end
        exp_alu = ins.alu;
        exp_rd  = ins.rd;
        exp_rw  = ins.rw;
        exp_ws  = ins.ws;
        if (ld) exp_rdata = rword;
        if (st && !timed_out) mem[waddr] = ins.wdata;
        if (timed_out) exp_fault = 1'b1;
        n_checks++;
        if (MEM_WB_ALU_OUT !== exp_alu || MEM_WB_RD !== exp_rd || MEM_WB_regwrite_en !== exp_rw ||
            MEM_WB_wb_sel !== exp_ws || MEM_WB_RDATA !== exp_rdata) begin
            n_fail++;
            $display("FAIL memwb got alu=%h rd=%0d rw=%b ws=%b rdata=%h exp alu=%h rd=%0d rw=%b ws=%b rdata=%h",
                     MEM_WB_ALU_OUT, MEM_WB_RD, MEM_WB_regwrite_en, MEM_WB_wb_sel, MEM_WB_RDATA,
                     exp_alu, exp_rd, exp_rw, exp_ws, exp_rdata);
        end
        n_checks++;
        if (dmem_fault !== exp_fault) begin
            n_fail++; $display("FAIL fault_after got=%b exp=%b", dmem_fault, exp_fault);
        end
    endtask

    task automatic model_reset();
        exp_alu = '0; exp_rdata = '0; exp_rd = '0; exp_rw = 1'b0; exp_ws = 1'b0; exp_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_random_inputs();
        EX_MEM_memwrite_en = 1'b1;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        model_reset();
        #12;
        n_checks++;
        if (MEM_WB_ALU_OUT !== 32'h0 || MEM_WB_RDATA !== 32'h0 || MEM_WB_RD !== 5'd0 ||
            MEM_WB_regwrite_en !== 1'b0 || MEM_WB_wb_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_memwb got alu=%h rdata=%h rd=%0d rw=%b ws=%b exp all 0",
                     MEM_WB_ALU_OUT, MEM_WB_RDATA, MEM_WB_RD, MEM_WB_regwrite_en, MEM_WB_wb_sel);
        end
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got req=%b stall=%b fault=%b exp 0/0/0", dmem_req, mem_stall, dmem_fault);
        end
        @(negedge clk);
        drive('{alu: 32'h0, wdata: 32'h0, rd: 5'd0, mw: 1'b0, rw: 1'b0, ws: 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_passthrough();
        run_instr('{alu: 32'h0000_1234, wdata: 32'h5555_AAAA, rd: 5'd5, mw: 1'b0, rw: 1'b1, ws: 1'b0}, 0, 1'b0);
    endtask

    task automatic test_zero_wait_load();
        mem[32'h100] = 32'hDEAD_BEEF;
        run_instr('{alu: 32'h0000_0103, wdata: 32'h0, rd: 5'd7, mw: 1'b0, rw: 1'b1, ws: 1'b1}, 0, 1'b0);
        n_checks++;
        if (MEM_WB_RDATA !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL zw_load_rdata got=%h exp=deadbeef", MEM_WB_RDATA);
        end
    endtask

    task automatic test_wait_store();
        run_instr('{alu: 32'h0000_0204, wdata: 32'hCAFE_F00D, rd: 5'd3, mw: 1'b1, rw: 1'b0, ws: 1'b0}, 3, 1'b0);
        run_instr('{alu: 32'h0000_0777, wdata: 32'h0, rd: 5'd11, mw: 1'b0, rw: 1'b1, ws: 1'b0}, 0, 1'b0);
        run_instr('{alu: 32'h0000_0204, wdata: 32'h0, rd: 5'd12, mw: 1'b0, rw: 1'b1, ws: 1'b1}, 2, 1'b1);
        n_checks++;
        if (MEM_WB_RDATA !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL store_readback got=%h exp=cafef00d", MEM_WB_RDATA);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive('{alu: 32'h0000_0300, wdata: 32'h0, rd: 5'd9, mw: 1'b0, rw: 1'b1, ws: 1'b1});
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || MEM_WB_RD !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_wait got req=%b stall=%b rd=%0d exp 0/0/0", dmem_req, mem_stall, MEM_WB_RD);
        end
        model_reset();
        @(negedge clk);
        drive('{alu: 32'h0, wdata: 32'h0, rd: 5'd0, mw: 1'b0, rw: 1'b0, ws: 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dmem_req !== 1'b0 || MEM_WB_RD !== 5'd0 || MEM_WB_regwrite_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_after got req=%b rd=%0d rw=%b exp 0/0/0", dmem_req, MEM_WB_RD, MEM_WB_regwrite_en);
        end
        run_instr('{alu: 32'h0000_0300, wdata: 32'h0, rd: 5'd9, mw: 1'b0, rw: 1'b1, ws: 1'b1}, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_instr('{alu: 32'h0000_0400, wdata: 32'h0, rd: 5'd13, mw: 1'b0, rw: 1'b1, ws: 1'b1}, 25, 1'b1);
        run_instr('{alu: 32'h0000_0042, wdata: 32'h0, rd: 5'd14, mw: 1'b0, rw: 1'b1, ws: 1'b0}, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        instr_t ins;
        int     kind;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            ins.alu   = 32'h1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            ins.wdata = $urandom;
            ins.rd    = 5'($urandom);
            case (kind)
                0: begin ins.alu = $urandom; ins.mw = 1'b0; ins.rw = 1'($urandom); ins.ws = 1'b0; end
                1: begin ins.mw = 1'b0; ins.rw = 1'b1; ins.ws = 1'b1; end
                2: begin ins.mw = 1'b1; ins.rw = 1'($urandom); ins.ws = 1'($urandom); end
                default: begin ins.mw = 1'($urandom); ins.rw = 1'($urandom); ins.ws = 1'($urandom); end
            endcase
            run_instr(ins, $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_zero_wait_load();
        test_wait_store();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

MEM stage of the pipelined RV32I core. It sits between the EX/MEM pipeline register and the writeback stage. It consumes the EX/MEM bundle (ALU result, store data, destination register, memwrite/regwrite/wb_sel controls) and runs word loads and stores on a data-memory port with a req/ready handshake. It stalls the upstream pipeline while a memory access is outstanding and loads the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before an access is aborted. Used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- EX_MEM_ALU_OUT  in  32  effective address, or ALU result for non-memory instructions.
- EX_MEM_writedata  in  32  store data.
- EX_MEM_RD  in  5  destination register.
- EX_MEM_memwrite_en  in  1  store.
- EX_MEM_regwrite_en  in  1  register writeback.
- EX_MEM_wb_sel  in  1  writeback source: 1 = memory, 0 = ALU.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word address, bits [1:0] forced to 0.
- dmem_wdata  out  32  write data.
- dmem_ready  in  1  access completes in this cycle.
- dmem_rdata  in  32  read data; valid when dmem_ready is 1.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- MEM_EX_ALU_OUT  out  32  forwarding value; combinational copy of EX_MEM_ALU_OUT.
- MEM_WB_ALU_OUT  out  32  registered ALU result.
- MEM_WB_RDATA  out  32  registered load data.
- MEM_WB_RD  out  5  registered destination register.
- MEM_WB_regwrite_en  out  1  registered writeback enable.
- MEM_WB_wb_sel  out  1  registered writeback source select.
- dmem_fault  out  1  sticky timeout flag.

## Operation
- Access classification:
  - store = EX_MEM_memwrite_en.
  - load = EX_MEM_wb_sel & EX_MEM_regwrite_en & ~EX_MEM_memwrite_en.
  - access = store | load.
- FSM states: IDLE, WAIT.
- IDLE with no access:
  - dmem_req = 0, mem_stall = 0.
  - MEM/WB loads the EX/MEM bundle at the next edge.
- IDLE with an access:
  - dmem_req = 1 combinationally; dmem_we = store; dmem_addr and dmem_wdata are driven from the EX/MEM inputs.
  - If dmem_ready = 1 (zero-wait): no stall. MEM/WB loads at the next edge; MEM_WB_RDATA = dmem_rdata for a load.
  - If dmem_ready = 0: mem_stall = 1. The block captures addr, wdata, we, RD, regwrite_en and wb_sel, and goes to WAIT.
- WAIT:
  - dmem_req = 1, driven from the captured values, which stay stable.
  - mem_stall = ~dmem_ready.
  - When dmem_ready = 1: MEM/WB loads the captured bundle (RDATA from dmem_rdata if the access is a load), the FSM returns to IDLE, and the upstream pipeline advances in the same cycle.
- Bubble: on every edge where mem_stall = 1, MEM/WB receives a bubble:
  - MEM_WB_regwrite_en = 0, MEM_WB_RD = 0, MEM_WB_wb_sel = 0.
  - MEM_WB_ALU_OUT and MEM_WB_RDATA hold their values.
- MEM_WB_RDATA changes only when a load completes. For non-loads it holds its previous value.
- A store completing with EX_MEM_regwrite_en = 1 is legal. MEM/WB loads its RD and regwrite_en normally.
- dmem_ready while dmem_req = 0 is ignored.

## Timing
- Reset: every registered output is 0, dmem_fault = 0, and the FSM is in IDLE.
- dmem_req, dmem_we, dmem_addr, dmem_wdata and mem_stall are combinational from the state and inputs. Asserting rst in WAIT drops dmem_req immediately. The access is abandoned; no MEM/WB update occurs.
- Latency from EX/MEM to MEM/WB:
  - 1 cycle for non-access and zero-wait accesses.
  - 1 + N cycles for an access that sees dmem_ready N cycles after the request first asserts.
- Back-to-back accesses: the cycle after completion, IDLE evaluates the next EX/MEM instruction. A request can therefore be issued every cycle.
- Upstream must hold EX/MEM stable while mem_stall = 1. The block relies only on its captured copy in WAIT.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A WAIT cycle counter (width $clog2(TIMEOUT_CYCLES+1)) is cleared on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES with dmem_ready still 0, the access completes as if dmem_ready = 1, with read data forced to 0, and dmem_fault is set.
  - dmem_fault stays set until rst.
- DMEM_TIMEOUT_EN undefined:
  - No counter is built; dmem_fault is tied to 0.
  - WAIT persists indefinitely until dmem_ready.

## Test plan
- Reset: rst pulse with inputs at arbitrary values -> all MEM_WB outputs = 0, dmem_req = 0, mem_stall = 0, dmem_fault = 0.
- ALU pass-through: ALU_OUT = 0x00001234, RD = 5, regwrite = 1, wb_sel = 0 -> next edge MEM_WB_ALU_OUT = 0x1234, MEM_WB_RD = 5; dmem_req never asserts.
- Zero-wait load: addr 0x00000103, RD = 7, dmem_ready = 1 same cycle, rdata = 0xDEADBEEF -> dmem_addr = 0x100; next edge MEM_WB_RDATA = 0xDEADBEEF, MEM_WB_wb_sel = 1; mem_stall stays 0.
- Wait-state store: addr 0x204, data 0xCAFEF00D, dmem_ready on the 4th request cycle -> dmem_req and dmem_we high 4 cycles with addr and data stable, mem_stall high 3 cycles, 3 bubbles with MEM_WB_regwrite_en = 0. A following ALU instruction appears at MEM/WB 1 cycle after completion.
- Reset mid-WAIT: load pending, rst asserted in the 2nd WAIT cycle -> dmem_req = 0 in the same cycle; after release the FSM is in IDLE and MEM_WB_RD = 0.
- Timeout (DMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4): load with dmem_ready held at 0 -> after 4 WAIT cycles mem_stall drops, MEM_WB_RDATA = 0, dmem_fault = 1 and stays 1. Without the macro, mem_stall stays high for 20+ cycles.
